// File: rtl/cpu_control_unit_if.sv
// Control-unit side of the CPU datapath: IR in, register strobes / bus select / ALU op / memory strobes out.
// master = control unit, slave = datapath.
interface cpu_control_unit_if;
    logic [7:0] ir;
    logic       loadIR, incIR, clrIR;
    logic       loadDR, incDR, clrDR;
    logic       loadPC, incPC, clrPC;
    logic       loadAR, incAR, clrAR;
    logic       loadAC, incAC, clrAC;
    logic [2:0] busSEL;
    logic [2:0] aluOpcode;
    logic       read;
    logic       write;
    logic [2:0] sc;
    logic [7:0] t;
    logic [7:0] d;
    logic       halted;

    modport master (
        input  ir,
        output loadIR, incIR, clrIR, loadDR, incDR, clrDR, loadPC, incPC, clrPC,
        output loadAR, incAR, clrAR, loadAC, incAC, clrAC,
        output busSEL, aluOpcode, read, write, sc, t, d, halted
    );

    modport slave (
        output ir,
        input  loadIR, incIR, clrIR, loadDR, incDR, clrDR, loadPC, incPC, clrPC,
        input  loadAR, incAR, clrAR, loadAC, incAC, clrAC,
        input  busSEL, aluOpcode, read, write, sc, t, d, halted
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Hardwired fetch/indirect/execute sequencer for the 8-bit accumulator CPU; strobes are combinational
// from (sc, ir, halted); 6 cycles for ADD/XNOR/LOAD, 5 for the rest; no backpressure, memory is single-cycle.
module cpu_control_unit #(
    parameter int OPW = 3,
    parameter int SCW = 3
) (
    input  logic          clk,
    input  logic          clr,
    cpu_control_unit_if.master cif
);
    typedef enum logic [SCW-1:0] {T0, T1, T2, T3, T4, T5, T6, T7} tstate_e;
    typedef enum logic [2:0] {
        BUS_NONE, BUS_AR, BUS_PC, BUS_DR, BUS_AC, BUS_IR, BUS_MEM
    } bus_e;

    localparam logic [OPW-1:0] OP_ADD   = 3'd0;
    localparam logic [OPW-1:0] OP_ASHL  = 3'd1;
    localparam logic [OPW-1:0] OP_XNOR  = 3'd2;
    localparam logic [OPW-1:0] OP_DIV2  = 3'd3;
    localparam logic [OPW-1:0] OP_LOAD  = 3'd4;
    localparam logic [OPW-1:0] OP_STORE = 3'd5;
    localparam logic [OPW-1:0] OP_COMP  = 3'd6;

    tstate_e        sc_q, sc_d;
    logic           halted_q, halted_d;
    logic [OPW-1:0] opcode;
    logic           ind;
    logic           ld_op, mem_op, unary_op;
    logic           load_ir, inc_pc, load_dr, load_ar, load_ac, rd, wr;
    bus_e           bus_sel;
    logic [2:0]     alu;

    assign opcode   = cif.ir[6:4];
    assign ind      = cif.ir[7];
    assign ld_op    = (opcode == OP_ADD) || (opcode == OP_XNOR) || (opcode == OP_LOAD);
    assign mem_op   = ld_op || (opcode == OP_STORE);
    assign unary_op = (opcode == OP_ASHL) || (opcode == OP_DIV2) || (opcode == OP_COMP);

    always_comb begin
        sc_d     = sc_q;
        halted_d = halted_q;
        load_ir  = 1'b0;
        inc_pc   = 1'b0;
        load_dr  = 1'b0;
        load_ar  = 1'b0;
        load_ac  = 1'b0;
        rd       = 1'b0;
        wr       = 1'b0;
        bus_sel  = BUS_NONE;
        alu      = 3'd0;
        if (halted_q) begin
            sc_d = T0;
        end else begin
            case (sc_q)
                T0: begin
                    bus_sel = BUS_PC;
                    load_ar = 1'b1;
                    sc_d    = T1;
                end
                T1: begin
                    rd      = 1'b1;
                    bus_sel = BUS_MEM;
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                    sc_d    = T2;
                end
                T2: begin
                    bus_sel = BUS_IR;
                    load_ar = 1'b1;
                    sc_d    = T3;
                end
                T3: begin
                    // Non-indirect and unary instructions still spend this cycle so timing stays uniform.
                    if (ind && mem_op) begin
                        rd      = 1'b1;
                        bus_sel = BUS_MEM;
                        load_ar = 1'b1;
                    end
                    sc_d = T4;
                end
                T4: begin
                    sc_d = T0;
                    if (ld_op) begin
                        rd      = 1'b1;
                        bus_sel = BUS_MEM;
                        load_dr = 1'b1;
                        sc_d    = T5;
                    end else if (opcode == OP_STORE) begin
                        bus_sel = BUS_AC;
                        wr      = 1'b1;
                    end else if (unary_op) begin
                        alu     = opcode;
                        load_ac = 1'b1;
                    end else begin
                        halted_d = 1'b1;
                    end
                end
                T5: begin
                    sc_d = T0;
                    if (ld_op) begin
                        bus_sel = BUS_DR;
                        alu     = opcode;
                        load_ac = 1'b1;
                    end
                end
                default: sc_d = T0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sc_q     <= T0;
            halted_q <= 1'b0;
        end else begin
            sc_q     <= sc_d;
            halted_q <= halted_d;
        end
    end

    // Strobes are masked during reset; the register clears are driven straight from clr.
    assign cif.loadIR    = load_ir & ~clr;
    assign cif.incIR     = 1'b0;
    assign cif.clrIR     = clr;
    assign cif.loadDR    = load_dr & ~clr;
    assign cif.incDR     = 1'b0;
    assign cif.clrDR     = clr;
    assign cif.loadPC    = 1'b0;
    assign cif.incPC     = inc_pc & ~clr;
    assign cif.clrPC     = clr;
    assign cif.loadAR    = load_ar & ~clr;
    assign cif.incAR     = 1'b0;
    assign cif.clrAR     = clr;
    assign cif.loadAC    = load_ac & ~clr;
    assign cif.incAC     = 1'b0;
    assign cif.clrAC     = clr;
    assign cif.busSEL    = clr ? 3'd0 : bus_sel;
    assign cif.aluOpcode = clr ? 3'd0 : alu;
    assign cif.read      = rd & ~clr;
    assign cif.write     = wr & ~clr;
    assign cif.sc        = sc_q;
    assign cif.t         = 8'b1 << sc_q;
    assign cif.d         = 8'b1 << opcode;
    assign cif.halted    = halted_q;
endmodule
